pong_score_counter: RTL and testbench

PONG_SCORE_COUNTER -- requirements
Module: pong_score_counter

---
 rtl/pong_pkg.sv | 22 ++
 rtl/bcd2_counter.sv | 54 +++++
 rtl/pong_score_counter.sv | 110 +++++++++++
 tb/tb_pong_score_counter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score counter: FSM states, default win score, BCD digit width.
package pong_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam int WIN_SCORE_DEF = 11;
    localparam int DIGIT_W       = 4;

    // Split a decimal score (0..99) into its BCD tens digit.
    function automatic logic [DIGIT_W-1:0] bcd_tens(input int value);
        return DIGIT_W'(value / 10);
    endfunction

    // Split a decimal score (0..99) into its BCD ones digit.
    function automatic logic [DIGIT_W-1:0] bcd_ones(input int value);
        return DIGIT_W'(value % 10);
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter that saturates at 99 and flags the increment that lands on WIN_SCORE.
module bcd2_counter
    import pong_pkg::*;
#(
    parameter int WIN_SCORE = WIN_SCORE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               reach_win
);

    localparam logic [DIGIT_W-1:0] WIN_TENS = bcd_tens(WIN_SCORE);
    localparam logic [DIGIT_W-1:0] WIN_ONES = bcd_ones(WIN_SCORE);

    logic [DIGIT_W-1:0] tens_reg, tens_next;
    logic [DIGIT_W-1:0] ones_reg, ones_next;
    logic               sat;

    assign sat = (tens_reg == 4'd9) && (ones_reg == 4'd9);

    always_comb begin
        tens_next = tens_reg;
        ones_next = ones_reg;
        if (!sat) begin
            if (ones_reg == 4'd9) begin
                ones_next = 4'd0;
                tens_next = tens_reg + 4'd1;
            end else begin
                ones_next = ones_reg + 4'd1;
            end
        end
    end

    // Looks at the post-increment value so the FSM can switch on the same edge that writes the score.
    assign reach_win = inc && !sat && (tens_next == WIN_TENS) && (ones_next == WIN_ONES);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            tens_reg <= '0;
            ones_reg <= '0;
        end else if (inc) begin
            tens_reg <= tens_next;
            ones_reg <= ones_next;
        end
    end

    assign tens = tens_reg;
    assign ones = ones_reg;

endmodule

// File: rtl/pong_score_counter.sv
// Pong scoreboard: edge-detects the two point inputs, keeps two BCD scores and latches the first winner.
module pong_score_counter
    import pong_pkg::*;
#(
    parameter int WIN_SCORE = WIN_SCORE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               point_l,
    input  logic               point_r,
    output logic [DIGIT_W-1:0] dig0,
    output logic [DIGIT_W-1:0] dig1,
    output logic [DIGIT_W-1:0] dig2,
    output logic [DIGIT_W-1:0] dig3,
    output logic               game_over,
    output logic               winner
);

    state_t state_reg, state_next;
    logic   winner_reg, winner_next;
    logic   prev_l_reg, prev_r_reg;
    logic   block_l_reg, block_r_reg;
    logic   edge_l, edge_r;
    logic   inc_l, inc_r;
    logic   reach_l, reach_r;

    // A level still high when reset releases is blocked until it drops, so it cannot score as a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_l_reg  <= 1'b0;
            prev_r_reg  <= 1'b0;
            block_l_reg <= point_l;
            block_r_reg <= point_r;
        end else begin
            prev_l_reg  <= point_l;
            prev_r_reg  <= point_r;
            block_l_reg <= block_l_reg & point_l;
            block_r_reg <= block_r_reg & point_r;
        end
    end

    assign edge_l = point_l & ~prev_l_reg & ~block_l_reg;
    assign edge_r = point_r & ~prev_r_reg & ~block_r_reg;
    assign inc_l  = edge_l & (state_reg == PLAY) & ~clr;
    assign inc_r  = edge_r & (state_reg == PLAY) & ~clr;

    bcd2_counter #(.WIN_SCORE(WIN_SCORE)) u_left (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .inc       (inc_l),
        .tens      (dig0),
        .ones      (dig1),
        .reach_win (reach_l)
    );

    bcd2_counter #(.WIN_SCORE(WIN_SCORE)) u_right (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .inc       (inc_r),
        .tens      (dig2),
        .ones      (dig3),
        .reach_win (reach_r)
    );

    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        if (clr) begin
            state_next  = PLAY;
            winner_next = 1'b0;
        end else begin
            unique case (state_reg)
                PLAY: begin
                    // Left is checked first so a simultaneous win goes to the left player.
                    if (reach_l) begin
                        state_next  = OVER;
                        winner_next = 1'b0;
                    end else if (reach_r) begin
                        state_next  = OVER;
                        winner_next = 1'b1;
                    end
                end
                OVER: begin
                    state_next  = OVER;
                end
                default: begin
                    state_next  = PLAY;
                    winner_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= PLAY;
            winner_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            winner_reg <= winner_next;
        end
    end

    assign game_over = (state_reg == OVER);
    assign winner    = winner_reg;

endmodule

// File: tb/tb_pong_score_counter.sv
// Scoreboard bench for pong_score_counter: one DUT at WIN_SCORE=11, one at WIN_SCORE=99.
module tb_pong_score_counter;

    typedef struct {
        int         s;
        logic [3:0] d0, d1, d2, d3;
        logic       go, w;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       pl  [2];
    logic       pr  [2];
    logic       cl  [2];
    logic       rs  [2];
    logic [3:0] o0 [2];
    logic [3:0] o1 [2];
    logic [3:0] o2 [2];
    logic [3:0] o3 [2];
    logic       ogo [2];
    logic       ow  [2];

    exp_t sb[$];
    int   checks = 0;
    int   bad    = 0;

    always #5 clk = ~clk;

    pong_score_counter #(.WIN_SCORE(11)) dut11 (
        .clk(clk), .reset(rs[0]), .clr(cl[0]), .point_l(pl[0]), .point_r(pr[0]),
        .dig0(o0[0]), .dig1(o1[0]), .dig2(o2[0]), .dig3(o3[0]),
        .game_over(ogo[0]), .winner(ow[0])
    );

    pong_score_counter #(.WIN_SCORE(99)) dut99 (
        .clk(clk), .reset(rs[1]), .clr(cl[1]), .point_l(pl[1]), .point_r(pr[1]),
        .dig0(o0[1]), .dig1(o1[1]), .dig2(o2[1]), .dig3(o3[1]),
        .game_over(ogo[1]), .winner(ow[1])
    );

    // Monitor: pops every expectation queued this cycle and compares it on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (o0[e.s] !== e.d0 || o1[e.s] !== e.d1 || o2[e.s] !== e.d2 ||
                o3[e.s] !== e.d3 || ogo[e.s] !== e.go || ow[e.s] !== e.w) begin
                bad++;
                $display("FAIL %s dut%0d: got dig=%h%h-%h%h go=%b w=%b, want dig=%h%h-%h%h go=%b w=%b",
                         e.nm, e.s, o0[e.s], o1[e.s], o2[e.s], o3[e.s], ogo[e.s], ow[e.s],
                         e.d0, e.d1, e.d2, e.d3, e.go, e.w);
            end else begin
                $display("ok   %s dut%0d: dig=%h%h-%h%h go=%b w=%b",
                         e.nm, e.s, o0[e.s], o1[e.s], o2[e.s], o3[e.s], ogo[e.s], ow[e.s]);
            end
        end
    end

    task automatic step(input int s, input logic l, input logic r, input logic c, input logic rst);
        pl[s] = l;
        pr[s] = r;
        cl[s] = c;
        rs[s] = rst;
        @(posedge clk);
        #1;
    endtask

    // Expected scores are given in decimal and queued as BCD digits.
    task automatic expect_state(input int s, input int lv, input int rv, input logic go,
                                input logic w, input string nm);
        exp_t e;
        e.s  = s;
        e.d0 = 4'(lv / 10);
        e.d1 = 4'(lv % 10);
        e.d2 = 4'(rv / 10);
        e.d3 = 4'(rv % 10);
        e.go = go;
        e.w  = w;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic pulse(input int s, input logic l, input logic r);
        step(s, l, r, 1'b0, 1'b0);
        step(s, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            pl[s] = 1'b0; pr[s] = 1'b0; cl[s] = 1'b0; rs[s] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        rs[0] = 1'b0;
        rs[1] = 1'b0;
        expect_state(0, 0, 0, 1'b0, 1'b0, "reset11");
        expect_state(1, 0, 0, 1'b0, 1'b0, "reset99");
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Left wins at 11; the 12th pulse is ignored.
        for (int i = 1; i <= 12; i++) begin
            pulse(0, 1'b1, 1'b0);
            expect_state(0, (i > 11) ? 11 : i, 0, (i >= 11), 1'b0, $sformatf("left_pulse%0d", i));
        end

        // clr together with a point edge in OVER: clear, no increment, back to PLAY.
        step(0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_state(0, 0, 0, 1'b0, 1'b0, "clr_with_point");
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(0, 1'b1, 1'b0);
        expect_state(0, 1, 0, 1'b0, 1'b0, "play_after_clr");

        // A held level scores exactly once.
        step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_state(0, 0, 0, 1'b0, 1'b0, "clr_before_hold");
        for (int k = 0; k < 5; k++) begin
            step(0, 1'b0, 1'b1, 1'b0, 1'b0);
            expect_state(0, 0, 1, 1'b0, 1'b0, $sformatf("hold_r%0d", k));
        end
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous edges: both reach 11 together, left takes the win.
        step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) pulse(0, 1'b1, 1'b1);
        expect_state(0, 10, 10, 1'b0, 1'b0, "both_at_10");
        pulse(0, 1'b1, 1'b1);
        expect_state(0, 11, 11, 1'b1, 1'b0, "both_win_left_prio");

        // Right wins alone; left points are ignored afterwards.
        step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            pulse(0, 1'b0, 1'b1);
            expect_state(0, 0, i, (i == 11), (i == 11), $sformatf("right_pulse%0d", i));
        end
        pulse(0, 1'b1, 1'b0);
        expect_state(0, 0, 11, 1'b1, 1'b1, "over_ignores_left");

        // Reset mid-game while point_l is high; the held level must not count after release.
        step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) pulse(0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) pulse(0, 1'b0, 1'b1);
        expect_state(0, 5, 7, 1'b0, 1'b0, "score_05_07");
        step(0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_state(0, 0, 0, 1'b0, 1'b0, "reset_mid_game");
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b1, 1'b0, 1'b0, 1'b0);
            expect_state(0, 0, 0, 1'b0, 1'b0, $sformatf("held_after_reset%0d", k));
        end
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_state(0, 1, 0, 1'b0, 1'b0, "rise_after_reset");
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Input low through reset and rising on the first free cycle does count.
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_state(0, 0, 1, 1'b0, 1'b0, "first_cycle_rise");
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // WIN_SCORE=99: carry at 9->10 and saturation at 99.
        for (int i = 1; i <= 100; i++) begin
            pulse(1, 1'b0, 1'b1);
            if (i == 9)
                expect_state(1, 0, 9, 1'b0, 1'b0, "r99_at_9");
            else if (i == 10)
                expect_state(1, 0, 10, 1'b0, 1'b0, "r99_carry_10");
            else if (i == 98)
                expect_state(1, 0, 98, 1'b0, 1'b0, "r99_at_98");
            else if (i >= 99)
                expect_state(1, 0, 99, 1'b1, 1'b1, $sformatf("r99_sat_%0d", i));
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
